program_counter: RTL and testbench

- 32-bit program-counter register for the single-cycle/pipelined CPU datapath.
- Loads `pcNext`, computed by the next-PC mux upstream, on every rising clock edge; drives the current `pc` to instruction fetch.
- Also provides `pc + 4` and an alignment flag to the fetch/branch logic.
- Sits between the next-PC selection mux and the instruction memory address port.

---
 rtl/cpu_pkg.sv | 9 +
 rtl/program_counter.sv | 50 +++++
 tb/tb_program_counter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: address width, address type, boot vector and PC increment.
package cpu_pkg;
  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] addr_t;

  localparam addr_t RESET_VECTOR = 32'h0000_0000;
  localparam int    PC_STEP      = 4;
endpackage

// File: rtl/program_counter.sv
// Program-counter register with a combinational pc+STEP output and a word-alignment flag.
// Optional PC_HISTORY_EN adds pcPrev (value before the most recent load) and a registered changed flag.
module program_counter
  import cpu_pkg::*;
#(
  parameter int               WIDTH       = XLEN,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(RESET_VECTOR),
  parameter int               STEP        = PC_STEP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] pcNext,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pcPlus4,
`ifdef PC_HISTORY_EN
  output logic [WIDTH-1:0] pcPrev,
  output logic             changed,
`endif
  output logic             misaligned
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VALUE;
    end else if (en) begin
      pc <= pcNext;
    end
  end

  // Sum wraps modulo 2^WIDTH; there is deliberately no carry-out.
  assign pcPlus4    = pc + WIDTH'(STEP);
  assign misaligned = |pc[1:0];

`ifdef PC_HISTORY_EN
  // Stalls hold pcPrev but clear changed, so changed marks only a real redirect of pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcPrev  <= RESET_VALUE;
      changed <= 1'b0;
    end else if (en) begin
      pcPrev  <= pc;
      changed <= (pcNext != pc);
    end else begin
      changed <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios plus random load/stall traffic
// checked against a simple behavioural model of the PC (and its history when PC_HISTORY_EN is set).
module tb_program_counter;
  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] pcNext;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        misaligned;
`ifdef PC_HISTORY_EN
  logic [31:0] pcPrev;
  logic        changed;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model
  logic [31:0] m_pc;
  logic [31:0] m_prev;
  logic        m_changed;

  program_counter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pcNext     (pcNext),
    .pc         (pc),
    .pcPlus4    (pcPlus4),
`ifdef PC_HISTORY_EN
    .pcPrev     (pcPrev),
    .changed    (changed),
`endif
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_plus4(input logic [31:0] v);
    longint unsigned s;
    s = (longint'(v) + 4) % 64'h1_0000_0000;
    return s[31:0];
  endfunction

  function automatic logic exp_mis(input logic [31:0] v);
    return (v % 4) != 0;
  endfunction

  // Advance one rising edge, update the model from the inputs seen at that edge.
  task automatic step();
    logic [31:0] nxt;
    logic        ld;
    nxt = pcNext;
    ld  = en;
    @(posedge clk);
    if (!rst_n) begin
      m_pc = 32'h0; m_prev = 32'h0; m_changed = 1'b0;
    end else if (ld) begin
      m_changed = (nxt != m_pc);
      m_prev    = m_pc;
      m_pc      = nxt;
    end else begin
      m_changed = 1'b0;
    end
    #1;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_prev = 32'h0; m_changed = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; pcNext = 32'h1234;
    model_reset();
    #2;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (pc !== 32'h0) begin
        n_fail++; $display("FAIL reset_hold[%0d] pc=%h expected=%h", i, pc, 32'h0);
      end
      n_checks++;
      if (misaligned !== 1'b0) begin
        n_fail++; $display("FAIL reset_misaligned[%0d] got=%b expected=0", i, misaligned);
      end
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (pc !== 32'h1234) begin
      n_fail++; $display("FAIL reset_release pc=%h expected=%h", pc, 32'h1234);
    end
    $display("reset: pc=%h after release", pc);
  endtask

  task automatic test_sequential();
    en = 1'b1;
    for (int v = 0; v < 10; v++) begin
      pcNext = 32'(v);
      step();
      n_checks++;
      if (pc !== 32'(v)) begin
        n_fail++; $display("FAIL seq_pc[%0d] pc=%h expected=%h", v, pc, 32'(v));
      end
      n_checks++;
      if (pcPlus4 !== 32'(v + 4)) begin
        n_fail++; $display("FAIL seq_plus4[%0d] got=%h expected=%h", v, pcPlus4, 32'(v + 4));
      end
      n_checks++;
      if (misaligned !== (v % 4 != 0)) begin
        n_fail++; $display("FAIL seq_misaligned[%0d] got=%b expected=%b", v, misaligned, (v % 4 != 0));
      end
      $display("seq: pcNext=%0d pc=%h pcPlus4=%h misaligned=%b", v, pc, pcPlus4, misaligned);
    end
  endtask

  task automatic test_stall();
    en = 1'b1; pcNext = 32'h40;
    step();
    en = 1'b0; pcNext = 32'h80;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (pc !== 32'h40) begin
        n_fail++; $display("FAIL stall_hold[%0d] pc=%h expected=%h", i, pc, 32'h40);
      end
    end
    en = 1'b1;
    step();
    n_checks++;
    if (pc !== 32'h80) begin
      n_fail++; $display("FAIL stall_resume pc=%h expected=%h", pc, 32'h80);
    end
    $display("stall: resumed pc=%h", pc);
  endtask

  task automatic test_wrap();
    en = 1'b1; pcNext = 32'hFFFF_FFFC;
    step();
    n_checks++;
    if (pcPlus4 !== 32'h0) begin
      n_fail++; $display("FAIL wrap_plus4 got=%h expected=%h", pcPlus4, 32'h0);
    end
    n_checks++;
    if (misaligned !== 1'b0) begin
      n_fail++; $display("FAIL wrap_misaligned got=%b expected=0", misaligned);
    end
    $display("wrap: pc=%h pcPlus4=%h", pc, pcPlus4);
  endtask

  task automatic test_async_reset();
    en = 1'b1; pcNext = 32'h100;
    step();
    n_checks++;
    if (pc !== 32'h100) begin
      n_fail++; $display("FAIL async_preload pc=%h expected=%h", pc, 32'h100);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (pc !== 32'h0) begin
      n_fail++; $display("FAIL async_reset pc=%h expected=%h", pc, 32'h0);
    end
    $display("async reset: pc=%h between edges", pc);
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      en     = ($urandom_range(0, 3) != 0);
      pcNext = ($urandom_range(0, 3) == 0) ? m_pc : $urandom;
      if (i % 17 == 0) pcNext = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      step();
      n_checks++;
      if (pc !== m_pc || pcPlus4 !== exp_plus4(m_pc) || misaligned !== exp_mis(m_pc)) begin
        n_fail++;
        $display("FAIL random[%0d] pc=%h plus4=%h mis=%b expected pc=%h plus4=%h mis=%b",
                 i, pc, pcPlus4, misaligned, m_pc, exp_plus4(m_pc), exp_mis(m_pc));
      end
`ifdef PC_HISTORY_EN
      n_checks++;
      if (pcPrev !== m_prev || changed !== m_changed) begin
        n_fail++;
        $display("FAIL random_hist[%0d] pcPrev=%h changed=%b expected pcPrev=%h changed=%b",
                 i, pcPrev, changed, m_prev, m_changed);
      end
`endif
      $display("random[%0d]: en=%b pc=%h", i, en, pc);
    end
  endtask

`ifdef PC_HISTORY_EN
  task automatic test_history();
    en = 1'b1; pcNext = 32'h8;
    step();
    pcNext = 32'hC;
    step();
    n_checks++;
    if (pcPrev !== 32'h8 || changed !== 1'b1) begin
      n_fail++; $display("FAIL hist_load pcPrev=%h changed=%b expected pcPrev=%h changed=1", pcPrev, changed, 32'h8);
    end
    step();
    n_checks++;
    if (changed !== 1'b0 || pcPrev !== 32'hC) begin
      n_fail++; $display("FAIL hist_reload pcPrev=%h changed=%b expected pcPrev=%h changed=0", pcPrev, changed, 32'hC);
    end
    pcNext = 32'h20; en = 1'b0;
    step();
    n_checks++;
    if (changed !== 1'b0 || pcPrev !== 32'hC) begin
      n_fail++; $display("FAIL hist_stall pcPrev=%h changed=%b expected pcPrev=%h changed=0", pcPrev, changed, 32'hC);
    end
    $display("history: pcPrev=%h changed=%b", pcPrev, changed);
  endtask
`endif

  initial begin
    rst_n = 1'b0; en = 1'b0; pcNext = 32'h0;
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_wrap();
    test_async_reset();
    test_random();
`ifdef PC_HISTORY_EN
    test_history();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
